// File: rtl/midi_route_sched.sv
// MIDI router byte scheduler: per-input FIFOs, message framing with running
// status and sysex, round-robin whole-message forwarding, and a panic sequence.
module midi_route_sched #(
    parameter int PORTS          = 16,
    parameter int DEPTH          = 16,
    parameter int LOCK_TIMEOUT   = 65535,
    parameter int DROP_CLOCK     = 1,
    parameter int PANIC_ON_RESET = 1
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [PORTS*8-1:0] rx_data,
    input  logic [PORTS-1:0]   rx_dv,
    output logic [PORTS*8-1:0] tx_data,
    output logic [PORTS-1:0]   tx_dv,
    input  logic [PORTS-1:0]   tx_ready,
    input  logic               route_we,
    input  logic [3:0]         route_sel,
    input  logic [PORTS-1:0]   route_mask,
    input  logic               panic,
    output logic               panic_busy,
    output logic [PORTS-1:0]   rx_ovf
);
    localparam int AW = $clog2(DEPTH);
    localparam int IW = (PORTS > 1) ? $clog2(PORTS) : 1;
    localparam int TW = $clog2(LOCK_TIMEOUT + 1);

    typedef enum logic [1:0] {S_IDLE, S_LOCK, S_PANIC} state_t;

    logic [7:0]       head [PORTS];
    logic [PORTS-1:0] empty_v;
    logic [PORTS-1:0] pop_v;
    logic [PORTS-1:0] ovf_set;

    genvar gi;
    generate
        for (gi = 0; gi < PORTS; gi++) begin : g_fifo
            logic [7:0]  mem_q [DEPTH];
            logic [AW:0] wp_q, rp_q;
            logic [7:0]  in_byte;
            logic        full, push_req, accept;

            assign in_byte  = rx_data[gi*8 +: 8];
            assign empty_v[gi] = (wp_q == rp_q);
            assign full     = (wp_q[AW] != rp_q[AW]) && (wp_q[AW-1:0] == rp_q[AW-1:0]);
            assign push_req = rx_dv[gi] && !((DROP_CLOCK != 0) && (in_byte == 8'hF8));
            // A pop in the same cycle frees a slot, so a full FIFO still accepts.
            assign accept   = push_req && (!full || pop_v[gi]);
            assign ovf_set[gi] = push_req && full && !pop_v[gi];
            assign head[gi] = mem_q[rp_q[AW-1:0]];

            always_ff @(posedge clk) begin
                if (accept) begin
                    mem_q[wp_q[AW-1:0]] <= in_byte;
                end
            end

            always_ff @(posedge clk) begin
                if (rst) begin
                    wp_q <= '0;
                    rp_q <= '0;
                end else begin
                    if (accept)    wp_q <= wp_q + 1'b1;
                    if (pop_v[gi]) rp_q <= rp_q + 1'b1;
                end
            end
        end
    endgenerate

    function automatic logic [1:0] data_len(input logic [7:0] s);
        return (s[7:4] == 4'hC || s[7:4] == 4'hD) ? 2'd1 : 2'd2;
    endfunction

    function automatic logic [1:0] sys_len(input logic [7:0] s);
        case (s)
            8'hF1, 8'hF3: return 2'd1;
            8'hF2:        return 2'd2;
            default:      return 2'd0;
        endcase
    endfunction

    state_t           state_q, state_d;
    logic [IW-1:0]    grant_q, grant_d, last_q, last_d;
    logic [PORTS-1:0] lock_q, lock_d;
    logic [1:0]       rem_q, rem_d;
    logic             sysex_q, sysex_d, started_q, started_d;
    logic [TW-1:0]    timer_q, timer_d;
    logic             pend_q, pend_d, fc_q, fc_d;
    logic [3:0]       ch_q, ch_d, sub_q, sub_d;
    logic [7:0]       rs_q [PORTS];
    logic [PORTS-1:0] route_q [PORTS];
    logic [PORTS-1:0] tx_dv_q;
    logic [PORTS*8-1:0] tx_data_q;
    logic [PORTS-1:0] ovf_q;

    logic             pop, issue, rs_we, out_valid, found, ready_ok;
    logic [7:0]       rs_val, out_byte, cur_head, cur_rs, panic_byte;
    logic [PORTS-1:0] out_mask;
    logic [IW-1:0]    pick, cand;
    logic             cur_empty;

    assign cur_head  = head[grant_q];
    assign cur_rs    = rs_q[grant_q];
    assign cur_empty = empty_v[grant_q];
    assign ready_ok  = ((tx_ready & lock_q) == lock_q);
    assign pop_v     = pop ? (PORTS'(1) << grant_q) : '0;

    // Round-robin search starting just after the last grant.
    always_comb begin
        int c;
        found = 1'b0;
        pick  = '0;
        cand  = '0;
        for (int i = 0; i < PORTS; i++) begin
            c    = (int'(last_q) + 1 + i) % PORTS;
            cand = IW'(c);
            if (!found && !empty_v[cand]) begin
                found = 1'b1;
                pick  = cand;
            end
        end
    end

    always_comb begin
        case (sub_q)
            4'd0, 4'd3, 4'd6: panic_byte = {4'hB, ch_q};
            4'd1:             panic_byte = 8'h78;
            4'd4:             panic_byte = 8'h79;
            4'd7:             panic_byte = 8'h7B;
            default:          panic_byte = 8'h00;
        endcase
        if (!fc_q) panic_byte = 8'hFC;
    end

    always_comb begin
        state_d   = state_q;
        grant_d   = grant_q;
        last_d    = last_q;
        lock_d    = lock_q;
        rem_d     = rem_q;
        sysex_d   = sysex_q;
        started_d = started_q;
        timer_d   = timer_q;
        pend_d    = pend_q | panic;
        fc_d      = fc_q;
        ch_d      = ch_q;
        sub_d     = sub_q;
        pop       = 1'b0;
        issue     = 1'b0;
        rs_we     = 1'b0;
        rs_val    = 8'h00;
        out_valid = 1'b0;
        out_mask  = '0;
        out_byte  = 8'h00;
        case (state_q)
            S_IDLE: begin
                if (pend_q) begin
                    state_d = S_PANIC;
                    pend_d  = panic;
                    fc_d    = 1'b0;
                    ch_d    = '0;
                    sub_d   = '0;
                end else if (found) begin
                    state_d   = S_LOCK;
                    grant_d   = pick;
                    last_d    = pick;
                    lock_d    = route_q[pick];
                    rem_d     = '0;
                    sysex_d   = 1'b0;
                    started_d = 1'b0;
                    timer_d   = '0;
                end
            end
            S_LOCK: begin
                if (cur_empty) begin
                    timer_d = timer_q + 1'b1;
                    if (timer_q == TW'(LOCK_TIMEOUT - 1)) begin
                        state_d   = S_IDLE;
                        sysex_d   = 1'b0;
                        started_d = 1'b0;
                    end
                end else begin
                    timer_d = '0;
                    if (cur_head >= 8'hF8) begin
                        if (ready_ok) begin
                            issue = 1'b1;
                            if (!started_q) state_d = S_IDLE;
                        end
                    end else if (!started_q) begin
                        if (cur_head[7]) begin
                            if (ready_ok) begin
                                issue     = 1'b1;
                                started_d = 1'b1;
                                rs_we     = 1'b1;
                                if (cur_head < 8'hF0) begin
                                    rs_val = cur_head;
                                    rem_d  = data_len(cur_head);
                                end else if (cur_head == 8'hF0) begin
                                    sysex_d = 1'b1;
                                end else begin
                                    rem_d = sys_len(cur_head);
                                    if (sys_len(cur_head) == 2'd0) state_d = S_IDLE;
                                end
                            end
                        end else if (cur_rs != 8'h00) begin
                            if (ready_ok) begin
                                issue     = 1'b1;
                                started_d = 1'b1;
                                rem_d     = data_len(cur_rs) - 2'd1;
                                if (data_len(cur_rs) == 2'd1) state_d = S_IDLE;
                            end
                        end else begin
                            pop     = 1'b1;
                            state_d = S_IDLE;
                        end
                    end else if (cur_head[7] && !(sysex_q && cur_head == 8'hF7)) begin
                        // Unexpected status mid-message: abandon and reframe it fresh.
                        state_d   = S_IDLE;
                        sysex_d   = 1'b0;
                        started_d = 1'b0;
                    end else if (ready_ok) begin
                        issue = 1'b1;
                        if (sysex_q) begin
                            if (cur_head == 8'hF7) begin
                                sysex_d = 1'b0;
                                state_d = S_IDLE;
                            end
                        end else begin
                            rem_d = rem_q - 2'd1;
                            if (rem_q == 2'd1) state_d = S_IDLE;
                        end
                    end
                end
                if (issue) begin
                    pop       = 1'b1;
                    out_valid = 1'b1;
                    out_mask  = lock_q;
                    out_byte  = cur_head;
                end
            end
            S_PANIC: begin
                if (&tx_ready) begin
                    out_valid = 1'b1;
                    out_mask  = '1;
                    out_byte  = panic_byte;
                    if (!fc_q) begin
                        fc_d = 1'b1;
                    end else if (sub_q == 4'd8) begin
                        sub_d = '0;
                        ch_d  = ch_q + 1'b1;
                        if (ch_q == 4'hF) state_d = S_IDLE;
                    end else begin
                        sub_d = sub_q + 1'b1;
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= S_IDLE;
            grant_q   <= '0;
            last_q    <= IW'(PORTS - 1);
            lock_q    <= '0;
            rem_q     <= '0;
            sysex_q   <= 1'b0;
            started_q <= 1'b0;
            timer_q   <= '0;
            pend_q    <= (PANIC_ON_RESET != 0);
            fc_q      <= 1'b0;
            ch_q      <= '0;
            sub_q     <= '0;
            tx_dv_q   <= '0;
            tx_data_q <= '0;
            ovf_q     <= '0;
            for (int i = 0; i < PORTS; i++) begin
                rs_q[i]    <= 8'h00;
                route_q[i] <= ~(PORTS'(1) << i);
            end
        end else begin
            state_q   <= state_d;
            grant_q   <= grant_d;
            last_q    <= last_d;
            lock_q    <= lock_d;
            rem_q     <= rem_d;
            sysex_q   <= sysex_d;
            started_q <= started_d;
            timer_q   <= timer_d;
            pend_q    <= pend_d;
            fc_q      <= fc_d;
            ch_q      <= ch_d;
            sub_q     <= sub_d;
            tx_dv_q   <= out_valid ? out_mask : '0;
            ovf_q     <= ovf_set;
            for (int i = 0; i < PORTS; i++) begin
                tx_data_q[i*8 +: 8] <= (out_valid && out_mask[i]) ? out_byte : 8'h00;
            end
            if (rs_we) rs_q[grant_q] <= rs_val;
            if (route_we && int'(route_sel) < PORTS) route_q[route_sel[IW-1:0]] <= route_mask;
        end
    end

    assign tx_dv      = tx_dv_q;
    assign tx_data    = tx_data_q;
    assign rx_ovf     = ovf_q;
    assign panic_busy = pend_q || (state_q == S_PANIC);

endmodule

// File: tb/tb_midi_route_sched.sv
// Scoreboard bench for midi_route_sched: stimulus queues expected output
// bytes; a negedge monitor compares each tx_dv strobe against the queue head.
module tb_midi_route_sched;
    localparam int P = 8;

    logic           clk = 1'b0;
    logic           rst;
    logic [P*8-1:0] rx_data;
    logic [P-1:0]   rx_dv;
    logic [P*8-1:0] tx_data;
    logic [P-1:0]   tx_dv;
    logic [P-1:0]   tx_ready;
    logic           route_we;
    logic [3:0]     route_sel;
    logic [P-1:0]   route_mask;
    logic           panic;
    logic           panic_busy;
    logic [P-1:0]   rx_ovf;

    typedef struct packed {
        logic [7:0] mask;
        logic [7:0] data;
    } exp_t;

    exp_t           q [$];
    exp_t           e;
    logic [P*8-1:0] ed;
    int             errors = 0;
    int             checks = 0;
    int             ovf_cnt = 0;

    midi_route_sched #(
        .PORTS(P), .DEPTH(4), .LOCK_TIMEOUT(16), .DROP_CLOCK(1), .PANIC_ON_RESET(1)
    ) dut (
        .clk(clk), .rst(rst), .rx_data(rx_data), .rx_dv(rx_dv),
        .tx_data(tx_data), .tx_dv(tx_dv), .tx_ready(tx_ready),
        .route_we(route_we), .route_sel(route_sel), .route_mask(route_mask),
        .panic(panic), .panic_busy(panic_busy), .rx_ovf(rx_ovf)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (!rst && tx_dv != '0) begin
            checks++;
            if (q.size() == 0) begin
                errors++;
                $display("FAIL unexpected_tx: tx_dv=%h tx_data=%h, required no output", tx_dv, tx_data);
            end else begin
                e  = q.pop_front();
                ed = '0;
                for (int i = 0; i < P; i++) if (e.mask[i]) ed[i*8 +: 8] = e.data;
                if (tx_dv !== e.mask || tx_data !== ed)
                    begin
                        errors++;
                        $display("FAIL tx_byte: tx_dv=%h tx_data=%h, required tx_dv=%h tx_data=%h",
                                 tx_dv, tx_data, e.mask, ed);
                    end
                else
                    $display("tx mask=%h byte=%h ok", tx_dv, e.data);
            end
        end
        ovf_cnt += $countones(rx_ovf);
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %h required %h", name, act, req);
        end else begin
            $display("check %s = %h ok", name, act);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [P-1:0] pm, input logic [7:0] b);
        for (int i = 0; i < P; i++) if (pm[i]) rx_data[i*8 +: 8] = b;
        rx_dv = pm;
        tick();
        rx_dv = '0;
    endtask

    task automatic send_msg(input int p, input int n, input logic [47:0] bytes);
        for (int i = 0; i < n; i++) send(P'(1) << p, bytes[47-8*i -: 8]);
    endtask

    task automatic exp_msg(input logic [7:0] mask, input int n, input logic [47:0] bytes);
        for (int i = 0; i < n; i++) q.push_back('{mask: mask, data: bytes[47-8*i -: 8]});
    endtask

    task automatic exp_panic();
        q.push_back('{mask: 8'hFF, data: 8'hFC});
        for (int ch = 0; ch < 16; ch++) begin
            exp_msg(8'hFF, 3, {4'hB, 4'(ch), 8'h78, 8'h00, 24'h0});
            exp_msg(8'hFF, 3, {4'hB, 4'(ch), 8'h79, 8'h00, 24'h0});
            exp_msg(8'hFF, 3, {4'hB, 4'(ch), 8'h7B, 8'h00, 24'h0});
        end
    endtask

    task automatic wait_panic();
        int n = 0;
        while (panic_busy && n < 400) begin
            tick();
            n++;
        end
        chk("panic_busy_drop", 64'(panic_busy), 64'd0);
    endtask

    task automatic drain();
        int n = 0;
        while (q.size() != 0 && n < 600) begin
            tick();
            n++;
        end
        checks++;
        if (q.size() != 0) begin
            errors++;
            $display("FAIL drain: pending=%0d required 0", q.size());
        end
        repeat (24) tick();
    endtask

    initial begin
        rst = 1'b1; rx_data = '0; rx_dv = '0; tx_ready = '1;
        route_we = 1'b0; route_sel = '0; route_mask = '0; panic = 1'b0;
        repeat (3) tick();
        chk("reset_tx_dv", 64'(tx_dv), 64'd0);
        chk("reset_tx_data", 64'(tx_data), 64'd0);
        chk("reset_rx_ovf", 64'(rx_ovf), 64'd0);
        chk("reset_panic_busy", 64'(panic_busy), 64'd1);
        rst = 1'b0;
        exp_panic();
        tick();
        wait_panic();
        drain();

        // Two inputs in the same cycle: input 0's message first, unbroken.
        exp_msg(8'hFE, 3, 48'h903C7F000000);
        exp_msg(8'hFD, 3, 48'h903C7F000000);
        send(8'h03, 8'h90); send(8'h03, 8'h3C); send(8'h03, 8'h7F);
        drain();

        // Running status continuation on input 2, then program change on input 3.
        exp_msg(8'hFB, 5, 48'h903C7F3E7F00);
        exp_msg(8'hF7, 2, 48'hC00500000000);
        send_msg(2, 5, 48'h903C7F3E7F00);
        repeat (6) tick();
        send_msg(3, 2, 48'hC00500000000);
        drain();

        // Dropped timing clock, then sysex with an embedded realtime byte.
        exp_msg(8'hEF, 6, 48'hF07D01FA02F7);
        send(8'h10, 8'hF8);
        send_msg(4, 6, 48'hF07D01FA02F7);
        drain();

        // Full FIFO with transmitters stalled: 4 kept, 2 dropped.
        tx_ready = '0;
        ovf_cnt  = 0;
        exp_msg(8'hDF, 4, 48'h903C7F3E0000);
        send_msg(5, 6, 48'h903C7F3E7F40);
        repeat (4) tick();
        chk("ovf_pulses", 64'(ovf_cnt), 64'd2);
        tx_ready = '1;
        drain();

        // Panic while input 5 is mid-message.
        exp_msg(8'hDF, 3, 48'h903C7F000000);
        exp_panic();
        send(8'h20, 8'h90);
        repeat (4) tick();
        panic = 1'b1;
        tick();
        panic = 1'b0;
        chk("panic_busy_set", 64'(panic_busy), 64'd1);
        repeat (2) tick();
        send_msg(5, 2, 48'h3C7F00000000);
        wait_panic();
        drain();

        // Route input 6 to output 0 only.
        route_sel = 4'd6; route_mask = 8'h01; route_we = 1'b1;
        tick();
        route_we = 1'b0;
        exp_msg(8'h01, 3, 48'h903C7F000000);
        send_msg(6, 3, 48'h903C7F000000);
        drain();

        // Sysex abandoned by lock timeout: 02 has no status and is discarded.
        exp_msg(8'h7F, 3, 48'hF001F7000000);
        send_msg(7, 2, 48'hF00100000000);
        repeat (30) tick();
        send_msg(7, 2, 48'h02F700000000);
        drain();

        // Empty route: bytes consumed silently.
        route_sel = 4'd3; route_mask = 8'h00; route_we = 1'b1;
        tick();
        route_we = 1'b0;
        send_msg(3, 3, 48'h903C7F000000);
        drain();

        // Reset while input 0 is locked mid-message with bytes queued.
        exp_msg(8'hFE, 1, 48'h900000000000);
        send(8'h01, 8'h90);
        repeat (4) tick();
        tx_ready = '0;
        send_msg(0, 4, 48'h3C7FC0050000);
        rst = 1'b1;
        tick();
        chk("rst_mid_tx_dv", 64'(tx_dv), 64'd0);
        chk("rst_mid_tx_data", 64'(tx_data), 64'd0);
        chk("rst_mid_panic_busy", 64'(panic_busy), 64'd1);
        rst = 1'b0;
        exp_panic();
        tx_ready = '1;
        tick();
        wait_panic();
        drain();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
